// File: rtl/simple_proc_pkg.sv
// Shared definitions for the set-bit scanner: default word width, the
// IDLE/SCAN state encoding and small bit-counting helpers.
package simple_proc_pkg;

  localparam int DEFAULT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // True when exactly one bit of v is set.
  function automatic logic one_hot32(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  // Number of set bits in v.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/set_bit_scanner_ffs_enc.sv
// Combinational find-first-set encoder: idx is the position of the lowest
// set bit of word, any flags a non-zero word. idx is 0 for an all-zero word.
module ffs_enc #(
  parameter int W = 32
) (
  input  logic [W-1:0]         word,
  output logic [$clog2(W)-1:0] idx,
  output logic                 any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |word;
    for (int i = W - 1; i >= 0; i--) begin
      if (word[i]) idx = ($clog2(W))'(i);
    end
  end

endmodule

// File: rtl/set_bit_scanner.sv
// Set-bit scanner: accepts a word and emits one beat per set bit, lowest
// index first, over a valid/ready output. An all-zero word yields a single
// beat flagged out_zero. flush aborts the scan in progress.
// Optional feature: define SET_BIT_SCANNER_POPCOUNT_EN to add out_count,
// the popcount of the accepted word held for the whole scan.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// SCAN  | presenting beats for the word held in work
module set_bit_scanner
  import simple_proc_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         in_word,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(W)-1:0] out_idx,
  output logic                 out_last,
  output logic                 out_zero
`ifdef SET_BIT_SCANNER_POPCOUNT_EN
  ,
  output logic [$clog2(W):0]   out_count
`endif
);

  state_t                 state;
  logic [W-1:0]           work;
  logic [W-1:0]           work_next;
  logic [W-1:0]           enc_word;
  logic [$clog2(W)-1:0]   enc_idx;
  logic                   enc_any;
  logic                   enc_last;
  logic                   accept;
  logic                   beat_done;

  assign in_ready  = (state == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign beat_done = (state == SCAN) && out_valid && out_ready && !flush;

  // Work word with the bit of the current beat removed.
  assign work_next = work & ~(W'(1) << out_idx);

  // One encoder serves both the first beat (from in_word) and each following
  // beat (from the work word after the current bit is retired), so outputs
  // can be registered without extra latency.
  assign enc_word = (state == IDLE) ? in_word : work_next;
  assign enc_last = !enc_any || one_hot32(32'(enc_word));

  ffs_enc #(.W(W)) u_ffs_enc (
    .word (enc_word),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  // Scan FSM with registered beat outputs; flush overrides any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_zero  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      work      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_zero  <= 1'b0;
    end else if (accept) begin
      state     <= SCAN;
      work      <= in_word;
      out_valid <= 1'b1;
      out_idx   <= enc_idx;
      out_last  <= enc_last;
      out_zero  <= !enc_any;
    end else if (beat_done) begin
      if (out_last) begin
        state     <= IDLE;
        work      <= '0;
        out_valid <= 1'b0;
        out_idx   <= '0;
        out_last  <= 1'b0;
        out_zero  <= 1'b0;
      end else begin
        work     <= work_next;
        out_idx  <= enc_idx;
        out_last <= enc_last;
      end
    end
  end

`ifdef SET_BIT_SCANNER_POPCOUNT_EN
  // Popcount captured at acceptance and held until the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (accept) begin
      out_count <= ($clog2(W) + 1)'(popcount32(32'(in_word)));
    end
  end
`endif

endmodule
